// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared types and constants for the MEM-stage data-memory responder
package rv_pipe_pkg;

    localparam int DMEM_DEPTH_WORDS = 256;
    localparam int DMEM_IDX_W       = $clog2(DMEM_DEPTH_WORDS);
    localparam int DMEM_DATA_W      = 32;
    localparam int DMEM_CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    typedef enum logic {
        RD,
        WR
    } dmem_op_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - EX_MEM to data-memory request/response bundle
interface data_memory_responder_if;
    import rv_pipe_pkg::*;

    logic                   MemRead_i;
    logic                   MemWrite_i;
    logic [31:0]            addr_i;
    logic [DMEM_DATA_W-1:0] data_i;
    logic [DMEM_DATA_W-1:0] data_o;
    logic                   valid_o;
    logic                   stall_o;
    logic                   err_o;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i,
        input  data_o, valid_o, stall_o, err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i,
        output data_o, valid_o, stall_o, err_o
    );

endinterface

// File: rtl/dmem_ram_array.sv
// rtl/dmem_ram_array.sv - single-port word RAM, write enable, registered read port
module dmem_ram_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Storage is deliberately left out of reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - wait-stated data-memory responder; DMEM_MISALIGN_CHECK_EN enables err_o
module data_memory_responder
    import rv_pipe_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int WAIT_STATES = 2,
    parameter int DATA_W      = DMEM_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    data_memory_responder_if.slave bus
);

    localparam int                    IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_W-1:0] WS_INIT = DMEM_CNT_W'(WAIT_STATES);

    dmem_state_t            state;
    logic [DMEM_CNT_W-1:0]  cnt;
    dmem_op_t               lat_op;
    logic [IDX_W-1:0]       lat_idx;
    logic [1:0]             lat_lsb;
    logic [DATA_W-1:0]      lat_data;
    logic                   valid_q;
    logic                   err_q;

    logic                   req;
    logic                   fire;
    logic                   acc_err;
    logic                   ram_en;
    dmem_op_t               acc_op;
    logic [IDX_W-1:0]       acc_idx;
    logic [1:0]             acc_lsb;
    logic [DATA_W-1:0]      acc_data;
    logic [DATA_W-1:0]      rd_data;
    logic                   unused_bits;

    assign req = bus.MemRead_i | bus.MemWrite_i;

    // With zero wait states the access fires straight from IDLE, before the latches are loaded.
    always_comb begin
        acc_op   = lat_op;
        acc_idx  = lat_idx;
        acc_lsb  = lat_lsb;
        acc_data = lat_data;
        if (state == IDLE) begin
            acc_op   = bus.MemWrite_i ? WR : RD;
            acc_idx  = bus.addr_i[2 +: IDX_W];
            acc_lsb  = bus.addr_i[1:0];
            acc_data = bus.data_i;
        end
    end

    assign fire = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (cnt == DMEM_CNT_W'(1)));

`ifdef DMEM_MISALIGN_CHECK_EN
    assign acc_err = |acc_lsb;
`else
    assign acc_err = 1'b0;
`endif

    // Gated by reset so a held zero-wait-state write cannot land while reset is asserted.
    assign ram_en = fire && !acc_err && rst_i;

    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .DATA_W      (DATA_W)
    ) u_ram (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (ram_en),
        .we    (acc_op == WR),
        .idx   (acc_idx),
        .wdata (acc_data),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_op   <= RD;
            lat_idx  <= '0;
            lat_lsb  <= '0;
            lat_data <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= fire;
            err_q   <= fire && acc_err;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_op   <= acc_op;
                        lat_idx  <= acc_idx;
                        lat_lsb  <= acc_lsb;
                        lat_data <= acc_data;
                        cnt      <= WS_INIT;
                        state    <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == DMEM_CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic zero_rd;

    // A misaligned read reports zero until the next good read refreshes the RAM output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            zero_rd <= 1'b0;
        end else if (fire && (acc_op == RD)) begin
            zero_rd <= acc_err;
        end
    end

    assign bus.data_o = zero_rd ? '0 : rd_data;
`else
    assign bus.data_o = rd_data;
`endif

    assign bus.valid_o  = valid_q;
    assign bus.err_o    = err_q;
    assign bus.stall_o  = ((state == IDLE) && req) || (state == WAIT);
    assign unused_bits  = ^{bus.addr_i[31:IDX_W+2], acc_lsb};

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench: WAIT_STATES=2 and WAIT_STATES=0 instances
module tb_data_memory_responder;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] addr_v [2];
    logic [31:0] wd     [2];
    logic        valid  [2];
    logic        stall  [2];
    logic        err    [2];
    logic [31:0] data   [2];

    logic [31:0] mem_m     [2][256];
    logic [31:0] last_dout [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    data_memory_responder_if bus0 ();
    data_memory_responder_if bus1 ();

    assign bus0.MemRead_i  = rd[0];
    assign bus0.MemWrite_i = wr[0];
    assign bus0.addr_i     = addr_v[0];
    assign bus0.data_i     = wd[0];
    assign bus1.MemRead_i  = rd[1];
    assign bus1.MemWrite_i = wr[1];
    assign bus1.addr_i     = addr_v[1];
    assign bus1.data_i     = wd[1];
    assign valid[0] = bus0.valid_o;
    assign stall[0] = bus0.stall_o;
    assign err[0]   = bus0.err_o;
    assign data[0]  = bus0.data_o;
    assign valid[1] = bus1.valid_o;
    assign stall[1] = bus1.stall_o;
    assign err[1]   = bus1.err_o;
    assign data[1]  = bus1.data_o;

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .DATA_W(32)) dut_ws2 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .DATA_W(32)) dut_ws0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Completion monitor: every valid_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid[0]) begin
                if (q0.size() == 0) check("unexpected_valid_ws2", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    check("data_ws2", data[0], e.data);
                    check("err_ws2", {31'd0, err[0]}, {31'd0, e.err});
                end
            end
            if (valid[1]) begin
                if (q1.size() == 0) check("unexpected_valid_ws0", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    check("data_ws0", data[1], e.data);
                    check("err_ws0", {31'd0, err[1]}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic do_req(input int sel, input bit w, input bit r,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        int   ws;
        bit   mis;
        ws  = (sel == 0) ? 2 : 0;
        mis = MIS_EN && (a[1:0] != 2'b00);
        e.err = mis;
        if (w) begin
            if (!mis) mem_m[sel][a[9:2]] = d;
            e.data = last_dout[sel];
        end else begin
            e.data = mis ? 32'd0 : mem_m[sel][a[9:2]];
            last_dout[sel] = e.data;
        end
        @(negedge clk);
        rd[sel] = r;
        wr[sel] = w;
        addr_v[sel] = a;
        wd[sel] = d;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        #1;
        n = 0;
        while (stall[sel] && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, ws + 1);
        check("valid_in_resp", {31'd0, valid[sel]}, 32'd1);
        // Request stays up across the RESP edge, as a not-yet-advanced pipeline would hold it.
        @(posedge clk);
        #1;
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          s;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr_v[i] = '0; wd[i] = '0; last_dout[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_data", data[0], 32'd0);
        check("rst_valid", {31'd0, valid[0]}, 32'd0);
        check("rst_stall", {31'd0, stall[0]}, 32'd0);
        check("rst_err", {31'd0, err[0]}, 32'd0);
        rst_n = 1'b1;

        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h400, 32'h1);
        do_req(0, 1'b0, 1'b1, 32'h000, 32'h0);
        do_req(0, 1'b1, 1'b1, 32'h20, 32'h5);
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h40, 32'h11111111);
        do_req(0, 1'b1, 1'b0, 32'h42, 32'h22222222);
        do_req(0, 1'b0, 1'b1, 32'h40, 32'h0);
        do_req(0, 1'b0, 1'b1, 32'h42, 32'h0);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0);

        do_req(1, 1'b1, 1'b0, 32'h84, 32'hCAFEF00D);
        do_req(1, 1'b0, 1'b1, 32'h84, 32'h0);
        do_req(1, 1'b0, 1'b1, 32'h484, 32'h0);

        // Reset while a write to 0x30 sits in WAIT: the old contents must survive.
        do_req(0, 1'b1, 1'b0, 32'h30, 32'hA5A50001);
        @(negedge clk);
        wr[0] = 1'b1; addr_v[0] = 32'h30; wd[0] = 32'h0BADF00D;
        #1;
        check("rwait_stall_idle", {31'd0, stall[0]}, 32'd1);
        @(negedge clk);
        check("rwait_stall_wait", {31'd0, stall[0]}, 32'd1);
        rst_n = 1'b0;
        wr[0] = 1'b0;
        #1;
        check("rwait_data", data[0], 32'd0);
        check("rwait_valid", {31'd0, valid[0]}, 32'd0);
        check("rwait_stall", {31'd0, stall[0]}, 32'd0);
        check("rwait_err", {31'd0, err[0]}, 32'd0);
        last_dout[0] = '0;
        last_dout[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rwait_no_late_valid", {31'd0, valid[0]}, 32'd0);
        do_req(0, 1'b0, 1'b1, 32'h30, 32'h0);

        for (int i = 0; i < 8; i++) begin
            s = i % 2;
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            do_req(s, 1'b1, 1'b0, a, d);
            do_req(s, 1'b0, 1'b1, a, 32'h0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty_ws2", q0.size(), 32'd0);
        check("sb_empty_ws0", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
